interposer_arbiter: RTL and testbench
=====================================

# interposer_arbiter

Per-direction bus arbiter for the multipoint interposer link. It samples the `{valid, dest}` request words produced by every node IO of one direction and picks one transmitter per arbitration round with round-robin fairness. It then drives each node's 3-bit control word: bit2 = Tx, bit1 = Rx, bit0 = bypass. Requests whose destination is more than MAX_HOPS away are granted to an intermediate node, which captures the message and forwards it.

## Interface
- `NODE_COUNT`, 8: nodes on the link.
- `NODE_COUNT_DIGIT`, 3: address width (log2 NODE_COUNT).
- `DIRECTION`, 0: 0 = traffic flows low to high index; 1 = high to low.
- `MAX_HOPS`, 7: maximum index distance from source to receiving node per transfer (1..NODE_COUNT-1).
- `REQ_W`, NODE_COUNT_DIGIT+1: width of one request word.
- `clk`  in  1  clock; all state updates on posedge (node IOs act on negedge).
- `reset`  in  1  reset, synchronous, active-low.
- `request_in`  in  NODE_COUNT*REQ_W  node i at `[i*REQ_W +: REQ_W]`; MSB = valid, low bits = destination.
- `control_out`  out  NODE_COUNT*3  node i at `[i*3 +: 3]`; {Tx, Rx, bypass}.
- `busy`  out  1  state ≠ IDLE.
- `grant_src`  out  NODE_COUNT_DIGIT  source of current/last grant.
- `grant_dst`  out  NODE_COUNT_DIGIT  receiving node of current/last grant.
- `err_bad_dir`  out  1  sticky; a valid request pointed the wrong way.
- `grant_count`  out  16  total grants issued, wraps at 2^16.

## Operation
- FSM states: IDLE, GRANT, GUARD.
- IDLE: scan nodes starting at round-robin pointer `ptr`, ascending modulo NODE_COUNT. Select the first node i whose request is valid and direction-legal.
  - Legal means dest > i for DIRECTION=0, dest < i for DIRECTION=1.
  - If a node is found, latch src = i and go to GRANT. Otherwise stay in IDLE.
- A valid, illegal request (dest == i or wrong side) is never granted and sets `err_bad_dir`. It clears only on reset.
- Target computation for DIRECTION=0: tgt = min(dest, i+MAX_HOPS). For DIRECTION=1: tgt = max(dest, i−MAX_HOPS). Compute with NODE_COUNT_DIGIT+1 bits so there is no wrap.
- GRANT (exactly 1 cycle), registered outputs:
  - Tx=1 for src.
  - Rx=1 for tgt.
  - bypass=1 for every node strictly between src and tgt.
  - All other bits 0.
  - `grant_src` = src, `grant_dst` = tgt, `grant_count` += 1.
  - `ptr` = (src+1) mod NODE_COUNT.
- GUARD (exactly 1 cycle): `control_out` = 0. This gives the granted node time to retire its FIFO entry and present its next request. Then go to IDLE.
- At most one Tx, one Rx, and a contiguous bypass run are active at a time. Tx and Rx never fall on the same node.
- The arbiter never inspects message data; forwarding is implicit because the Rx node re-requests.

## Timing
- Reset (posedge with reset=0): state IDLE, `ptr` = 0, and every output is 0 (`control_out`, `busy`, `grant_src`, `grant_dst`, `err_bad_dir`, `grant_count`).
- Reset asserted during GRANT or GUARD aborts immediately; `control_out` is 0 from the next cycle on.
- Request sampled at posedge T (state IDLE) → `control_out` valid for cycle T+1 → 0 in cycle T+2 (GUARD) → next sample at posedge T+3.
- Minimum grant spacing is 3 cycles. A single continuously requesting node gets one grant every 3 cycles.
- `busy` = 1 exactly during GRANT and GUARD.
- Round-robin bound: a continuously valid, legal requester is granted within NODE_COUNT rounds.
- Requests changing during GRANT or GUARD are ignored; only the IDLE sample matters.
- `grant_count` wraps 0xFFFF → 0x0000.

## Test plan
- Reset: hold reset=0 for 3 cycles with all requests valid → `control_out`=0, `busy`=0, `grant_count`=0, `err_bad_dir`=0.
- Single hop, DIRECTION=0: node 2 requests dest 5 → in the GRANT cycle node 2 = 3'b100, nodes 3–4 = 3'b001, node 5 = 3'b010, others 0. `grant_src`=2, `grant_dst`=5, `busy` high for 2 cycles.
- Hop limit: MAX_HOPS=2, node 1 requests dest 6 → Rx on node 3, bypass on node 2, `grant_dst`=3. Then node 3 requests dest 6 → Rx on node 5. Then node 5 requests dest 6 → Rx on node 6.
- Fairness: nodes 0, 3, 6 request continuously (legal) → grants in order 0, 3, 6, 0, … with a 3-cycle spacing and `grant_count` incrementing by 1 per grant.
- Bad direction: DIRECTION=0, node 5 requests dest 2 and node 4 requests dest 4 → no grant, `busy`=0, `err_bad_dir`=1 and it stays 1 after the requests drop.
- Mid-grant reset plus mirror: DIRECTION=1, node 7 requests dest 4, reset=0 asserted in the GRANT cycle → all outputs 0 next cycle. After release, the grant reissues with Tx on node 7, bypass on nodes 6–5, Rx on node 4.

Source files
------------

// File: rtl/interposer_arbiter.sv
// interposer_arbiter: round-robin per-direction bus arbiter driving {Tx,Rx,bypass} per node
module interposer_arbiter #(
  parameter int NODE_COUNT = 8,
  parameter int NODE_COUNT_DIGIT = 3,
  parameter int DIRECTION = 0,
  parameter int MAX_HOPS = 7,
  parameter int REQ_W = NODE_COUNT_DIGIT + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NODE_COUNT*REQ_W-1:0]   request_in,
  output logic [NODE_COUNT*3-1:0]       control_out,
  output logic                          busy,
  output logic [NODE_COUNT_DIGIT-1:0]   grant_src,
  output logic [NODE_COUNT_DIGIT-1:0]   grant_dst,
  output logic                          err_bad_dir,
  output logic [15:0]                   grant_count
);
  localparam int D = NODE_COUNT_DIGIT;
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
  state_t state_q, state_d;
  logic [D-1:0] ptr_q, ptr_d, src_q, src_d, dst_q, dst_d;
  logic [NODE_COUNT*3-1:0] ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [NODE_COUNT-1:0] legal;
  logic [D-1:0] dest_a [NODE_COUNT];
  logic [D-1:0] tgt_a [NODE_COUNT];
  logic [D:0] hop, s;
  logic [D-1:0] idx, sel, sel_tgt;
  logic bad, found, go;
  logic [NODE_COUNT*3-1:0] pat;
  // Per-node legality and hop-limited target, computed with one spare bit so nothing wraps
  always_comb begin
    bad = 1'b0;
    legal = '0;
    hop = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      dest_a[i] = request_in[i*REQ_W +: D];
      legal[i] = request_in[i*REQ_W+REQ_W-1] &&
                 (DIRECTION == 0 ? dest_a[i] > D'(i) : dest_a[i] < D'(i));
      bad = bad | (request_in[i*REQ_W+REQ_W-1] & ~legal[i]);
      if (DIRECTION == 0) begin
        hop = (D+1)'(i) + (D+1)'(MAX_HOPS);
        tgt_a[i] = {1'b0, dest_a[i]} < hop ? dest_a[i] : hop[D-1:0];
      end else begin
        hop = {1'b0, dest_a[i]} + (D+1)'(MAX_HOPS);
        tgt_a[i] = hop < (D+1)'(i) ? D'(i - MAX_HOPS) : dest_a[i];
      end
    end
  end
  // First legal requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    sel = '0;
    s = '0;
    idx = '0;
    for (int k = 0; k < NODE_COUNT; k++) begin
      s = {1'b0, ptr_q} + (D+1)'(k);
      idx = s >= (D+1)'(NODE_COUNT) ? D'(s - (D+1)'(NODE_COUNT)) : s[D-1:0];
      if (!found && legal[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    sel_tgt = tgt_a[sel];
  end
  always_comb begin
    pat = '0;
    for (int j = 0; j < NODE_COUNT; j++) begin
      pat[j*3+2] = D'(j) == sel;
      pat[j*3+1] = D'(j) == sel_tgt;
      pat[j*3] = DIRECTION == 0 ? (D'(j) > sel && D'(j) < sel_tgt)
                                : (D'(j) < sel && D'(j) > sel_tgt);
    end
  end
  always_comb begin
    go = state_q == IDLE && found;
    state_d = state_q == IDLE ? (found ? GRANT : IDLE) : state_q == GRANT ? GUARD : IDLE;
    ctrl_d = go ? pat : '0;
    src_d = go ? sel : src_q;
    dst_d = go ? sel_tgt : dst_q;
    cnt_d = go ? cnt_q + 16'd1 : cnt_q;
    ptr_d = go ? (sel == D'(NODE_COUNT-1) ? '0 : sel + 1'b1) : ptr_q;
    err_d = err_q | (state_q == IDLE && bad);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      ctrl_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      src_q <= src_d;
      dst_q <= dst_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign control_out = ctrl_q;
  assign busy = state_q != IDLE;
  assign grant_src = src_q;
  assign grant_dst = dst_q;
  assign err_bad_dir = err_q;
  assign grant_count = cnt_q;
endmodule

// File: tb/tb_interposer_arbiter.sv
// tb_interposer_arbiter: directed checks on three arbiter configurations sharing clk and reset
module tb_interposer_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] req0, req1, req2;
  logic [23:0] ctl0, ctl1, ctl2;
  logic busy0, busy1, busy2, err0, err1, err2;
  logic [2:0] src0, src1, src2, dst0, dst1, dst2;
  logic [15:0] cnt0, cnt1, cnt2;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  interposer_arbiter #(.DIRECTION(0), .MAX_HOPS(7)) d0 (
    .clk(clk), .reset(reset), .request_in(req0), .control_out(ctl0), .busy(busy0),
    .grant_src(src0), .grant_dst(dst0), .err_bad_dir(err0), .grant_count(cnt0));
  interposer_arbiter #(.DIRECTION(0), .MAX_HOPS(2)) d1 (
    .clk(clk), .reset(reset), .request_in(req1), .control_out(ctl1), .busy(busy1),
    .grant_src(src1), .grant_dst(dst1), .err_bad_dir(err1), .grant_count(cnt1));
  interposer_arbiter #(.DIRECTION(1), .MAX_HOPS(7)) d2 (
    .clk(clk), .reset(reset), .request_in(req2), .control_out(ctl2), .busy(busy2),
    .grant_src(src2), .grant_dst(dst2), .err_bad_dir(err2), .grant_count(cnt2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rq(input int node, input int dest);
    logic [31:0] r;
    r = '0;
    r[node*4 +: 4] = {1'b1, 3'(dest)};
    return r;
  endfunction
  logic [23:0] fair_ctl [3];
  int fair_src [3];
  initial begin
    fair_ctl[0] = 24'h000014; fair_ctl[1] = 24'h002800; fair_ctl[2] = 24'h500000;
    fair_src[0] = 0; fair_src[1] = 3; fair_src[2] = 6;
    req0 = '1; req1 = '1; req2 = '1;
    repeat (3) tick();
    chk("rst_ctl", ctl0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_err", err0, 0);
    req0 = '0; req1 = '0; req2 = '0;
    reset = 1'b1;
    tick();
    req0 = rq(0, 1) | rq(3, 4) | rq(6, 7);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("fair_ctl", ctl0, fair_ctl[g % 3]);
      chk("fair_src", src0, fair_src[g % 3]);
      chk("fair_cnt", cnt0, g + 1);
      if (g == 3) req0 = '0;
      tick();
      chk("fair_guard", ctl0, 0);
      chk("fair_guard_busy", busy0, 1);
      tick();
      chk("fair_idle_busy", busy0, 0);
    end
    req0 = rq(2, 5);
    tick();
    req0 = '0;
    chk("hop_ctl", ctl0, 24'h011300);
    chk("hop_src", src0, 2);
    chk("hop_dst", dst0, 5);
    chk("hop_busy", busy0, 1);
    tick();
    chk("hop_guard_ctl", ctl0, 0);
    chk("hop_guard_busy", busy0, 1);
    tick();
    chk("hop_idle_busy", busy0, 0);
    chk("hop_cnt", cnt0, 5);
    req0 = rq(5, 2) | rq(4, 4);
    tick();
    chk("bad_busy", busy0, 0);
    chk("bad_err", err0, 1);
    tick();
    tick();
    chk("bad_busy2", busy0, 0);
    chk("bad_cnt", cnt0, 5);
    chk("bad_ctl", ctl0, 0);
    req0 = '0;
    tick();
    tick();
    chk("bad_sticky", err0, 1);
    req1 = rq(1, 6);
    tick();
    req1 = '0;
    chk("lim1_ctl", ctl1, 24'h000460);
    chk("lim1_dst", dst1, 3);
    tick();
    tick();
    req1 = rq(3, 6);
    tick();
    req1 = '0;
    chk("lim2_ctl", ctl1, 24'h011800);
    chk("lim2_dst", dst1, 5);
    tick();
    tick();
    req1 = rq(5, 6);
    tick();
    req1 = '0;
    chk("lim3_ctl", ctl1, 24'h0A0000);
    chk("lim3_dst", dst1, 6);
    chk("lim_cnt", cnt1, 3);
    chk("lim_err", err1, 0);
    tick();
    tick();
    req2 = rq(7, 4);
    tick();
    chk("mir_pre_busy", busy2, 1);
    reset = 1'b0;
    tick();
    chk("mir_rst_ctl", ctl2, 0);
    chk("mir_rst_busy", busy2, 0);
    chk("mir_rst_cnt", cnt2, 0);
    chk("mir_rst_src", src2, 0);
    chk("mir_rst_err0", err0, 0);
    reset = 1'b1;
    tick();
    chk("mir_ctl", ctl2, 24'h84A000);
    chk("mir_src", src2, 7);
    chk("mir_dst", dst2, 4);
    chk("mir_cnt", cnt2, 1);
    chk("mir_err", err2, 0);
    req2 = '0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
